// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath width and the multiply
// sequencer state encoding.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XORR = 4'd4,
    SHL  = 4'd5,
    SHR  = 4'd6,
    EQ   = 4'd7,
    NE   = 4'd8,
    LT   = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ADD    = 3'd2,
    S_SHIFTA = 3'd3,
    S_SHIFTB = 3'd4,
    S_DONE   = 3'd5
  } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/result handshake plus the ALU operand/opcode bus of the multiply
// sequencer; the slave modport is the sequencer's own view.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 8
);
  import alu_pkg::*;

  // Request and result channels both use valid/ready: a transfer happens on a
  // rising edge where valid and ready are high together; valid never waits on ready.
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] product;
  logic             busy;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  alu_op_t          alu_op;
  logic             alu_sc_in;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  mul_state_t       dbg_state;

  modport slave (
    input  start_valid, op_a, op_b, res_ready, alu_out, alu_zero,
    output start_ready, res_valid, product, busy,
           alu_a, alu_b, alu_op, alu_sc_in, dbg_state
  );

  modport master (
    output start_valid, op_a, op_b, res_ready, alu_out, alu_zero,
    input  start_ready, res_valid, product, busy,
           alu_a, alu_b, alu_op, alu_sc_in, dbg_state
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the shared combinational ALU for every
// arithmetic step; returns the low WIDTH bits of op_a*op_b.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  alu_mul_sequencer_if.slave  bus
);

  localparam logic [3:0] ITER_LAST = 4'(MAX_ITER - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [3:0]       iter_q, iter_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      iter_q   <= iter_d;
    end
  end

  // Each state drives one ALU operation and captures its result in the same cycle.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    iter_d     = iter_q;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = ADD;

    case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          acc_d    = '0;
          iter_d   = '0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        bus.alu_a  = mplier_q;
        bus.alu_b  = ONE;
        bus.alu_op = AND;
        state_d    = bus.alu_zero ? S_SHIFTA : S_ADD;
      end
      S_ADD: begin
        bus.alu_a  = acc_q;
        bus.alu_b  = mcand_q;
        bus.alu_op = ADD;
        acc_d      = bus.alu_out;
        state_d    = S_SHIFTA;
      end
      S_SHIFTA: begin
        bus.alu_a  = mcand_q;
        bus.alu_b  = ONE;
        bus.alu_op = SHL;
        mcand_d    = bus.alu_out;
        state_d    = S_SHIFTB;
      end
      S_SHIFTB: begin
        bus.alu_a  = mplier_q;
        bus.alu_b  = ONE;
        bus.alu_op = SHR;
        mplier_d   = bus.alu_out;
        iter_d     = iter_q + 4'd1;
        // Cap bounds the loop even if the ALU never reports zero.
        state_d    = (bus.alu_zero || iter_q == ITER_LAST) ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.start_ready = (state_q == S_IDLE);
  assign bus.res_valid   = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.product     = (state_q == S_DONE) ? acc_q : '0;
  assign bus.alu_sc_in   = 1'b0;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer driving a behavioural model of the
// shared ALU; expected products and cycle counts are worked out by hand.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  alu_mul_sequencer_if #(.WIDTH(ALU_W)) bus ();

  alu_mul_sequencer #(.WIDTH(ALU_W), .MAX_ITER(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Behavioural stand-in for the shared combinational ALU.
  always_comb begin
    case (bus.alu_op)
      ADD:     bus.alu_out = bus.alu_a + bus.alu_b;
      SUB:     bus.alu_out = bus.alu_a - bus.alu_b;
      AND:     bus.alu_out = bus.alu_a & bus.alu_b;
      OR:      bus.alu_out = bus.alu_a | bus.alu_b;
      XORR:    bus.alu_out = bus.alu_a ^ bus.alu_b;
      SHL:     bus.alu_out = bus.alu_a << bus.alu_b;
      SHR:     bus.alu_out = bus.alu_a >> bus.alu_b;
      EQ:      bus.alu_out = ALU_W'(bus.alu_a == bus.alu_b);
      NE:      bus.alu_out = ALU_W'(bus.alu_a != bus.alu_b);
      LT:      bus.alu_out = ALU_W'(bus.alu_a < bus.alu_b);
      default: bus.alu_out = '0;
    endcase
  end
  assign bus.alu_zero = (bus.alu_out == '0);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    Reset           = 1'b1;
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // Returns #1 after the accept edge (state is CHECK there).
  task automatic start_req(input logic [7:0] a, input logic [7:0] b);
    bus.start_valid = 1'b1;
    bus.op_a        = a;
    bus.op_b        = b;
    @(posedge Clk);
    #1;
    bus.start_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until res_valid is seen (bounded).
  task automatic wait_done(output int cycles, output int n_add, output int n_shb);
    cycles = 0;
    n_add  = 0;
    n_shb  = 0;
    while (bus.res_valid !== 1'b1 && cycles < 100) begin
      @(posedge Clk);
      #1;
      cycles++;
      if (bus.dbg_state == S_ADD)    n_add++;
      if (bus.dbg_state == S_SHIFTB) n_shb++;
    end
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.res_ready = 1'b0;
  endtask

  function automatic logic [31:0] reset_vec_expected();
    return {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'(ADD), 1'b0};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] got;
    apply_reset();
    got = {bus.start_ready, bus.res_valid, bus.busy, bus.product,
           bus.alu_a, bus.alu_b, 4'(bus.alu_op), bus.alu_sc_in};
    n_cmp++;
    if (got !== reset_vec_expected()) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", got, reset_vec_expected());
    end
  endtask

  task automatic test_single_bit();
    logic [3:0] exp_q[$];
    logic [3:0] e;
    exp_q = {4'(AND), 4'(ADD), 4'(SHL), 4'(SHR)};
    start_req(8'd4, 8'd1);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (4'(bus.alu_op) !== e) begin
        n_err++;
        $display("FAIL op_seq_4x1[%0d]: got %0d expected %0d", i, bus.alu_op, e);
      end
      @(posedge Clk);
      #1;
    end
    // op_b=1: one set bit, 4 edges after accept to DONE
    n_cmp++;
    if (bus.res_valid !== 1'b1 || bus.product !== 8'h04) begin
      n_err++;
      $display("FAIL result_4x1: got valid=%b product=%h expected valid=1 product=04",
               bus.res_valid, bus.product);
    end
    take_result();
    n_cmp++;
    if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_4x1: got ready=%b busy=%b expected ready=1 busy=0",
               bus.start_ready, bus.busy);
    end
  endtask

  task automatic run_case(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_p, input int exp_cyc,
                          input int exp_add, input int exp_shb, input bit release_res);
    int cyc, nadd, nshb;
    start_req(a, b);
    wait_done(cyc, nadd, nshb);
    n_cmp++;
    if (cyc !== exp_cyc || bus.res_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_latency: got %0d edges (valid=%b) expected %0d", name, cyc,
               bus.res_valid, exp_cyc);
    end
    n_cmp++;
    if (bus.product !== exp_p) begin
      n_err++;
      $display("FAIL %s_product: got %h expected %h", name, bus.product, exp_p);
    end
    n_cmp++;
    if (nadd !== exp_add || nshb !== exp_shb) begin
      n_err++;
      $display("FAIL %s_steps: got add=%0d iter=%0d expected add=%0d iter=%0d", name,
               nadd, nshb, exp_add, exp_shb);
    end
    if (release_res) take_result();
  endtask

  task automatic test_back_pressure();
    run_case("bp_13x11", 8'd13, 8'd11, 8'h8F, 15, 3, 4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.start_valid = i[0];
      bus.op_a        = 8'h55;
      bus.op_b        = 8'h03;
      @(posedge Clk);
      #1;
      n_cmp++;
      if (bus.res_valid !== 1'b1 || bus.product !== 8'h8F || bus.start_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_%0d: got valid=%b product=%h ready=%b expected 1/8f/0", i,
                 bus.res_valid, bus.product, bus.start_ready);
      end
    end
    bus.start_valid = 1'b0;
    take_result();
    n_cmp++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL release: got ready=%b valid=%b busy=%b expected 1/0/0",
               bus.start_ready, bus.res_valid, bus.busy);
    end
    @(posedge Clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL not_queued: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] got;
    start_req(8'd13, 8'd11);
    @(posedge Clk);
    #1;
    n_cmp++;
    if (bus.dbg_state !== S_ADD) begin
      n_err++;
      $display("FAIL abort_in_add: got state %0d expected %0d", bus.dbg_state, S_ADD);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    got = {bus.start_ready, bus.res_valid, bus.busy, bus.product,
           bus.alu_a, bus.alu_b, 4'(bus.alu_op), bus.alu_sc_in};
    n_cmp++;
    if (got !== reset_vec_expected()) begin
      n_err++;
      $display("FAIL abort_outputs: got %h expected %h", got, reset_vec_expected());
    end
    @(posedge Clk);
    #1;
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_stale: got valid=%b busy=%b expected 0/0",
               bus.res_valid, bus.busy);
    end
    // 2*3: two set bits -> 8 edges, 6
    run_case("after_abort_2x3", 8'd2, 8'd3, 8'h06, 8, 2, 2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_bit();
    // 13*11=143; bits 1,1,0,1 -> 4+4+3+4 edges
    run_case("mul_13x11", 8'd13, 8'd11, 8'h8F, 15, 3, 4, 1'b1);
    // 255*255=0xFE01 wraps to 0x01; eight set bits, stops at the iteration cap
    run_case("mul_ff_ff", 8'hFF, 8'hFF, 8'h01, 32, 8, 8, 1'b1);
    // op_b=0: CHECK, SHIFTA, SHIFTB then DONE; no ADD
    run_case("mul_c8_00", 8'hC8, 8'h00, 8'h00, 3, 0, 1, 1'b1);
    test_back_pressure();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
